mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between instruction fetch (IF) and data access (D)
//  for the RISC-V core. One access in flight at a time; memory has fixed read latency.
//  D wins by default; an anti-starvation counter forces an IF grant. Sits between the
//  program counter / load-store path and a single-port memory macro.
// PARAMETERS
//  ADDR_W      64  byte-address width, both requesters and memory
//  DATA_W      64  memory data width (doubleword)
//  MEM_LAT     2   cycles mem_en is held per access; rdata sampled at end of last cycle (>=1)
//  STARVE_LIM  3   consecutive D grants while if_req pending before IF is forced (>=1)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset
//  if_req     in   1       fetch request; held until if_ready
//  if_addr    in   ADDR_W  fetch byte address
//  if_ready   out  1       fetch accepted this cycle (transfer = if_req & if_ready)
//  if_rvalid  out  1       one-cycle pulse: if_rdata valid
//  if_rdata   out  32      fetched instruction word
//  if_err     out  1       with if_rvalid: if_addr[1:0]!=0, access suppressed, if_rdata=0
//  d_req      in   1       data request; held until d_ready
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data byte address
//  d_wdata    in   DATA_W  store data
//  d_ready    out  1       data accepted this cycle
//  d_rvalid   out  1       one-cycle pulse: load data valid / store complete
//  d_rdata    out  DATA_W  load data (0 for stores)
//  d_err      out  1       with d_rvalid: d_addr[2:0]!=0, access suppressed, d_rdata=0
//  mem_en     out  1       memory access enable
//  mem_we     out  1       memory write enable (only with mem_en)
//  mem_addr   out  ADDR_W  doubleword-aligned address (low 3 bits forced 0)
//  mem_wdata  out  DATA_W  write data
//  mem_rdata  in   DATA_W  read data, valid at end of last mem_en cycle
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE, all outputs 0, starve count 0, latched request
//    cleared; any in-flight access is abandoned, no rvalid produced for it.
//  - FSM: IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: if any req, grant one; assert its *_ready combinationally this cycle; latch owner,
//    addr, we, wdata, error flag; go BUSY. No req: stay IDLE. Only one ready high per cycle.
//    BUSY: mem_en=1 (unless error) with latched fields for exactly MEM_LAT cycles (counter
//    0..MEM_LAT-1); on last cycle capture mem_rdata; go RESP.
//    RESP: owner's rvalid=1 for one cycle with data/err; go IDLE. No grant in BUSY/RESP.
//  - Latency: accept at cycle t; mem_en t+1..t+MEM_LAT; rvalid at t+MEM_LAT+1.
//    Max throughput one access per MEM_LAT+2 cycles.
//  - Arbitration in IDLE: only one req -> grant it. Both -> D, unless starve count ==
//    STARVE_LIM, then IF. Starve count: +1 on D grant while if_req=1 (saturates at
//    STARVE_LIM); cleared on IF grant or on D grant with if_req=0.
//  - if_rdata = latched addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
//  - Error accesses: full BUSY duration still elapses, mem_en=0, mem_we=0, no memory effect.
//  - Requests are sampled only at acceptance; inputs may change freely afterwards.
//  - req dropped in IDLE before ready: no grant, no state change.
//  - Outputs other than *_ready are registered.
// STRUCTURE
//  - Shared include mem_arb_defs.vh: FSM state encodings (IDLE/BUSY/RESP), OWNER_IF/OWNER_D.
//  - Sub-module mem_arb_pick: starve counter + grant selection (req inputs, grant outputs,
//    update strobe). Top holds FSM, latency counter, request latch, response registers.
// TESTING (MEM_LAT=2, STARVE_LIM=3, memory model returns addr-derived data)
//  1 Single fetch if_addr=0x104, mem[0x100]=0xAAAA_BBBB_1111_2222 -> if_ready t, mem_en t+1..t+2
//    with mem_addr=0x100, if_rvalid t+3, if_rdata=0xAAAABBBB, if_err=0.
//  2 Store d_addr=0x200, d_wdata=0x55 then load 0x200 -> mem_we=1 for 2 cycles, d_rvalid
//    d_rdata=0; load returns d_rdata=0x55.
//  3 if_req and d_req held high continuously -> grant order D,D,D,IF,D,D,D,IF.
//  4 d_addr=0x203 load -> mem_en stays 0, d_rvalid at t+3 with d_err=1, d_rdata=0.
//  5 reset low during BUSY -> all outputs 0 immediately; after release, no rvalid for old
//    access; fresh if_req granted from IDLE in first cycle.
//  6 if_req pulsed 1 cycle during BUSY, then dropped -> no if_ready, no if_rvalid ever.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, request owner,
// and the alignment rule that decides whether an access is suppressed.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  // Fetches need word alignment, data accesses need doubleword alignment.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic is_fetch);
    if (is_fetch) begin
      return (addr_lo[1:0] != 2'b00);
    end else begin
      return (addr_lo != 3'b000);
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Grant selection between fetch and data requesters with an anti-starvation
// counter that forces a fetch grant after STARVE_LIM back-to-back data wins.
module mem_port_arbiter_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic update,
  output logic grant_if,
  output logic grant_d
);

  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [CW-1:0] starve_r;
  logic [CW-1:0] starve_next_s;

  // Grant decision and starve-count update.
  always_comb begin
    grant_if      = 1'b0;
    grant_d       = 1'b0;
    starve_next_s = starve_r;
    if (if_req && d_req) begin
      if (starve_r == LIM) begin
        grant_if = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
    end else if (if_req) begin
      grant_if = 1'b1;
    end else if (d_req) begin
      grant_d = 1'b1;
    end else begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
    end

    if (!update) begin
      starve_next_s = starve_r;
    end else if (grant_d && if_req) begin
      starve_next_s = (starve_r == LIM) ? LIM : starve_r + CW'(1);
    end else if (grant_if || grant_d) begin
      starve_next_s = {CW{1'b0}};
    end else begin
      starve_next_s = starve_r;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r <= {CW{1'b0}};
    end else begin
      starve_r <= starve_next_s;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access:
// one access in flight, fixed MEM_LAT busy window, one-cycle response pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);

  state_e            state_r, state_next_s;
  owner_e            owner_r;
  logic              err_r, we_r, word_hi_r;
  logic [LW-1:0]     lat_cnt_r;
  logic              grant_if_s, grant_d_s, accept_s, last_s, update_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              sel_we_s, sel_err_s;
  logic              if_rvalid_r, if_err_r, d_rvalid_r, d_err_r;
  logic [31:0]       if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r, mem_wdata_r;
  logic              mem_en_r, mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;

  assign update_s = (state_r == ST_IDLE);

  mem_port_arbiter_pick #(.STARVE_LIM(STARVE_LIM)) u_pick (
    .clk      (clk),
    .rst_n    (reset),
    .if_req   (if_req),
    .d_req    (d_req),
    .update   (update_s),
    .grant_if (grant_if_s),
    .grant_d  (grant_d_s)
  );

  // Next state and combinational ready handshake; ready is held low during reset.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    if_ready     = 1'b0;
    d_ready      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((grant_if_s || grant_d_s) && reset) begin
          accept_s     = 1'b1;
          if_ready     = grant_if_s;
          d_ready      = grant_d_s;
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (lat_cnt_r == LAT_LAST) begin
          last_s       = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Fields of the winning request, latched on acceptance.
  always_comb begin
    if (grant_d_s) begin
      sel_addr_s = d_addr;
      sel_we_s   = d_we;
      sel_err_s  = is_misaligned(d_addr[2:0], 1'b0);
    end else begin
      sel_addr_s = if_addr;
      sel_we_s   = 1'b0;
      sel_err_s  = is_misaligned(if_addr[2:0], 1'b1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch, memory drive, latency counter and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r     <= OWNER_IF;
      err_r       <= 1'b0;
      we_r        <= 1'b0;
      word_hi_r   <= 1'b0;
      lat_cnt_r   <= {LW{1'b0}};
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      if_rvalid_r <= 1'b0;
      if_err_r    <= 1'b0;
      if_rdata_r  <= 32'd0;
      d_rvalid_r  <= 1'b0;
      d_err_r     <= 1'b0;
      d_rdata_r   <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      owner_r     <= grant_d_s ? OWNER_D : OWNER_IF;
      err_r       <= sel_err_s;
      we_r        <= sel_we_s;
      word_hi_r   <= sel_addr_s[2];
      lat_cnt_r   <= {LW{1'b0}};
      mem_en_r    <= !sel_err_s;
      mem_we_r    <= sel_we_s && !sel_err_s;
      mem_addr_r  <= {sel_addr_s[ADDR_W-1:3], 3'b000};
      mem_wdata_r <= (sel_we_s && !sel_err_s) ? d_wdata : {DATA_W{1'b0}};
    end else if (state_r == ST_BUSY) begin
      if (last_s) begin
        mem_en_r    <= 1'b0;
        mem_we_r    <= 1'b0;
        mem_addr_r  <= {ADDR_W{1'b0}};
        mem_wdata_r <= {DATA_W{1'b0}};
        if (owner_r == OWNER_D) begin
          d_rvalid_r <= 1'b1;
          d_err_r    <= err_r;
          d_rdata_r  <= (err_r || we_r) ? {DATA_W{1'b0}} : mem_rdata;
        end else begin
          if_rvalid_r <= 1'b1;
          if_err_r    <= err_r;
          if_rdata_r  <= err_r ? 32'd0 : (word_hi_r ? mem_rdata[63:32] : mem_rdata[31:0]);
        end
      end else begin
        lat_cnt_r <= lat_cnt_r + LW'(1);
      end
    end else if (state_r == ST_RESP) begin
      if_rvalid_r <= 1'b0;
      if_err_r    <= 1'b0;
      if_rdata_r  <= 32'd0;
      d_rvalid_r  <= 1'b0;
      d_err_r     <= 1'b0;
      d_rdata_r   <= {DATA_W{1'b0}};
    end
  end

  assign if_rvalid = if_rvalid_r;
  assign if_err    = if_err_r;
  assign if_rdata  = if_rdata_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_err     = d_err_r;
  assign d_rdata   = d_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// single-requester traffic checked against a word-level memory model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_LIM = 3;
  localparam int RSP_LAT    = MEM_LAT + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [63:0] if_addr = 64'd0, d_addr = 64'd0, d_wdata = 64'd0;
  logic        if_ready, if_rvalid, if_err, d_ready, d_rvalid, d_err;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic both_seen = 1'b0;
  logic mem_loaded = 1'b0;
  logic [63:0] dut_mem [0:255];
  logic [63:0] ref_mem [0:255];

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(input logic [7:0] i);
    if (i == 8'd32) return 64'hAAAA_BBBB_1111_2222;
    return {16'hC0DE, 8'h00, i, 16'h0BAD, 8'h00, i};
  endfunction

  wire any_out = |{if_ready, if_rvalid, if_rdata, if_err, d_ready, d_rvalid, d_rdata, d_err,
                   mem_en, mem_we, mem_addr, mem_wdata};

  assign mem_rdata = mem_en ? dut_mem[mem_addr[10:3]] : 64'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) dut_mem[i] <= init_val(8'(i));
      mem_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      dut_mem[mem_addr[10:3]] <= mem_wdata;
    end
  end

  always @(negedge clk) if (if_ready && d_ready) both_seen <= 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Drives one request, then reports what the DUT did with it (no judging here).
  task automatic access(input bit is_d, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rdata, output bit err, output int lat,
                        output int en_n, output int we_n, output logic [63:0] maddr, output bit to);
    int t0;
    bit seen;
    to = 1'b0; en_n = 0; we_n = 0; maddr = 64'd0; rdata = 64'd0; err = 1'b0; lat = -1; t0 = 0;
    @(posedge clk); #1;
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (is_d ? d_ready : if_ready) begin seen = 1'b1; t0 = cyc; end
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin
      to = 1'b1; if_req = 1'b0; d_req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom}; if_addr = {$urandom, $urandom};
    d_we = 1'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_en) begin en_n++; maddr = mem_addr; end
      if (mem_we) we_n++;
      if (is_d ? d_rvalid : if_rvalid) begin
        seen = 1'b1; lat = cyc - t0;
        rdata = is_d ? d_rdata : {32'd0, if_rdata};
        err = is_d ? d_err : if_err;
      end
    end
    if (!seen) to = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b1; d_req = 1'b1; if_addr = 64'h104; d_addr = 64'h200;
    repeat (3) @(negedge clk);
    n_checks++;
    if (any_out !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: got any_out=%b need 0", any_out); end
    @(posedge clk); #1; if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (any_out !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got any_out=%b need 0", any_out); end
  endtask

  task automatic test_fetch();
    logic [63:0] rd, ma; bit er, to; int lat, en, wn;
    access(1'b0, 1'b0, 64'h104, 64'd0, rd, er, lat, en, wn, ma, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL fetch_timeout: got %0d need 0", to); end
    n_checks++;
    if (lat !== RSP_LAT) begin n_fail++; $display("FAIL fetch_latency: got %0d need %0d", lat, RSP_LAT); end
    n_checks++;
    if (en !== MEM_LAT) begin n_fail++; $display("FAIL fetch_mem_en_cycles: got %0d need %0d", en, MEM_LAT); end
    n_checks++;
    if (ma !== 64'h100) begin n_fail++; $display("FAIL fetch_mem_addr: got %h need 100", ma); end
    n_checks++;
    if (rd !== 64'h0000_0000_AAAA_BBBB || er !== 1'b0) begin
      n_fail++; $display("FAIL fetch_data: got %h err=%b need aaaabbbb err=0", rd, er);
    end
  endtask

  task automatic test_store_load();
    logic [63:0] rd, ma; bit er, to; int lat, en, wn;
    access(1'b1, 1'b1, 64'h200, 64'h55, rd, er, lat, en, wn, ma, to);
    ref_mem[64] = 64'h55;
    n_checks++;
    if (to !== 1'b0 || wn !== MEM_LAT || ma !== 64'h200) begin
      n_fail++; $display("FAIL store_mem: got to=%0d we_cycles=%0d addr=%h need 0/%0d/200", to, wn, ma, MEM_LAT);
    end
    n_checks++;
    if (rd !== 64'd0 || er !== 1'b0 || lat !== RSP_LAT) begin
      n_fail++; $display("FAIL store_resp: got data=%h err=%b lat=%0d need 0/0/%0d", rd, er, lat, RSP_LAT);
    end
    access(1'b1, 1'b0, 64'h200, 64'd0, rd, er, lat, en, wn, ma, to);
    n_checks++;
    if (rd !== 64'h55 || er !== 1'b0 || wn !== 0) begin
      n_fail++; $display("FAIL load_back: got data=%h err=%b we_cycles=%0d need 55/0/0", rd, er, wn);
    end
  endtask

  task automatic test_error();
    logic [63:0] rd, ma; bit er, to; int lat, en, wn;
    access(1'b1, 1'b0, 64'h203, 64'd0, rd, er, lat, en, wn, ma, to);
    n_checks++;
    if (to !== 1'b0 || en !== 0 || er !== 1'b1 || rd !== 64'd0 || lat !== RSP_LAT) begin
      n_fail++; $display("FAIL d_misaligned: got to=%0d en=%0d err=%b data=%h lat=%0d need 0/0/1/0/%0d",
                         to, en, er, rd, lat, RSP_LAT);
    end
    access(1'b1, 1'b1, 64'h20C, 64'hDEAD, rd, er, lat, en, wn, ma, to);
    n_checks++;
    if (en !== 0 || wn !== 0 || er !== 1'b1 || dut_mem[65] !== ref_mem[65]) begin
      n_fail++; $display("FAIL d_misaligned_store: got en=%0d we=%0d err=%b mem=%h need 0/0/1/%h",
                         en, wn, er, dut_mem[65], ref_mem[65]);
    end
    access(1'b0, 1'b0, 64'h102, 64'd0, rd, er, lat, en, wn, ma, to);
    n_checks++;
    if (en !== 0 || er !== 1'b1 || rd !== 64'd0 || lat !== RSP_LAT) begin
      n_fail++; $display("FAIL if_misaligned: got en=%0d err=%b data=%h lat=%0d need 0/1/0/%0d", en, er, rd, lat, RSP_LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    int n, starve, last_t, bad_gap;
    exp = 8'd0; got = 8'd0; starve = 0;
    for (int g = 0; g < 8; g++) begin
      if (starve == STARVE_LIM) begin exp[g] = 1'b0; starve = 0; end
      else begin exp[g] = 1'b1; starve = starve + 1; end
    end
    n = 0; last_t = -1; bad_gap = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h308;
    for (int k = 0; k < 80 && n < 8; k++) begin
      @(negedge clk);
      if (d_ready || if_ready) begin
        got[n] = d_ready;
        if (last_t >= 0 && cyc - last_t != MEM_LAT + 2) bad_gap++;
        last_t = cyc;
        n++;
      end
    end
    @(posedge clk); #1; if_req = 1'b0; d_req = 1'b0;
    repeat (MEM_LAT + 4) @(negedge clk);
    n_checks++;
    if (n !== 8 || got !== exp) begin
      n_fail++; $display("FAIL grant_order: got %0d grants order=%b need 8 order=%b (1=D, bit0 first)", n, got, exp);
    end
    n_checks++;
    if (bad_gap !== 0) begin n_fail++; $display("FAIL grant_spacing: got %0d bad gaps need 0", bad_gap); end
    n_checks++;
    if (both_seen !== 1'b0) begin n_fail++; $display("FAIL one_ready: got both ready high need never"); end
  endtask

  task automatic test_pulse();
    int ifr, ifv, dv;
    bit seen;
    ifr = 0; ifv = 0; dv = 0; seen = 1'b0;
    @(posedge clk); #1; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h210;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (d_ready) seen = 1'b1; else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1; d_req = 1'b0; if_req = 1'b1; if_addr = 64'h120;
    @(negedge clk); if (if_ready) ifr++;
    @(posedge clk); #1; if_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if_ready) ifr++;
      if (if_rvalid) ifv++;
      if (d_rvalid) dv++;
    end
    n_checks++;
    if (ifr !== 0 || ifv !== 0) begin n_fail++; $display("FAIL busy_pulse: got if_ready=%0d if_rvalid=%0d need 0/0", ifr, ifv); end
    n_checks++;
    if (!seen || dv !== 1) begin n_fail++; $display("FAIL busy_pulse_d: got accepted=%0d d_rvalid=%0d need 1/1", seen, dv); end
  endtask

  task automatic test_reset_busy();
    int dv, lat, t0;
    logic [31:0] data;
    bit seen;
    dv = 0; lat = -1; t0 = 0; data = 32'd0; seen = 1'b0;
    @(posedge clk); #1; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h208;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (d_ready) seen = 1'b1; else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1; d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || !seen) begin n_fail++; $display("FAIL busy_before_reset: got mem_en=%b need 1", mem_en); end
    #2; reset = 1'b0; #1;
    n_checks++;
    if (any_out !== 1'b0) begin n_fail++; $display("FAIL reset_in_busy: got any_out=%b need 0", any_out); end
    if_req = 1'b1; if_addr = 64'h110;
    @(posedge clk); @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    t0 = cyc;
    n_checks++;
    if (if_ready !== 1'b1) begin n_fail++; $display("FAIL first_grant_after_reset: got if_ready=%b need 1", if_ready); end
    @(posedge clk); #1; if_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_rvalid) dv++;
      if (if_rvalid && lat < 0) begin lat = cyc - t0; data = if_rdata; end
    end
    n_checks++;
    if (dv !== 0) begin n_fail++; $display("FAIL stale_rvalid: got %0d d_rvalid pulses need 0", dv); end
    n_checks++;
    if (lat !== RSP_LAT || data !== ref_mem[34][31:0]) begin
      n_fail++; $display("FAIL fetch_after_reset: got lat=%0d data=%h need %0d/%h", lat, data, RSP_LAT, ref_mem[34][31:0]);
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, ma, addr, wdata, exp_rd;
    bit er, to, is_d, we, exp_err;
    int lat, en, wn, exp_en, exp_wn;
    logic [7:0] idx;
    for (int it = 0; it < 40; it++) begin
      is_d  = 1'($urandom);
      we    = is_d & 1'($urandom);
      idx   = 8'($urandom_range(0, 255));
      addr  = {53'd0, idx, 3'b000};
      if (!is_d) addr[2] = 1'($urandom);
      if ($urandom_range(0, 5) == 0) addr[2:0] = 3'($urandom_range(1, 7));
      wdata = {$urandom, $urandom};
      exp_err = is_d ? (addr[2:0] != 3'b000) : (addr[1:0] != 2'b00);
      if (exp_err || we) exp_rd = 64'd0;
      else if (is_d) exp_rd = ref_mem[idx];
      else exp_rd = {32'd0, addr[2] ? ref_mem[idx][63:32] : ref_mem[idx][31:0]};
      exp_en = exp_err ? 0 : MEM_LAT;
      exp_wn = (we && !exp_err) ? MEM_LAT : 0;
      access(is_d, we, addr, wdata, rd, er, lat, en, wn, ma, to);
      if (we && !exp_err) ref_mem[idx] = wdata;
      n_checks++;
      if (to !== 1'b0 || rd !== exp_rd || er !== exp_err || lat !== RSP_LAT) begin
        n_fail++; $display("FAIL rand_resp[%0d]: d=%0d we=%0d addr=%h got data=%h err=%b lat=%0d to=%0d need %h/%b/%0d/0",
                           it, is_d, we, addr, rd, er, lat, to, exp_rd, exp_err, RSP_LAT);
      end
      n_checks++;
      if (en !== exp_en || wn !== exp_wn || (en != 0 && ma !== {addr[63:3], 3'b000})) begin
        n_fail++; $display("FAIL rand_mem[%0d]: got en=%0d we=%0d addr=%h need %0d/%0d/%h",
                           it, en, wn, ma, exp_en, exp_wn, {addr[63:3], 3'b000});
      end
    end
    n_checks++;
    for (int i = 0; i < 256; i++) if (dut_mem[i] !== ref_mem[i]) begin
      n_fail++; $display("FAIL mem_contents[%0d]: got %h need %h", i, dut_mem[i], ref_mem[i]);
      break;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    test_reset();
    test_fetch();
    test_store_load();
    test_error();
    test_back_to_back();
    test_pulse();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
